program_loader: RTL and testbench

- Sequential DMA-style loader that sits directly upstream of the instruction memory.
- On a start request it copies a block of 32-bit words from the HD (disk) read port into instruction memory, using the memory's write port (entradaDeInstrucao, posicaoParaSalvarInstrucao, controleSalvaInstrucao).
- Used by the lfhd path to pull the OS or a user program into instruction memory before or while the BIOS runs.
- Reports busy, done and range errors to the control unit.

---
 rtl/program_loader.sv | 186 ++++++++++++++++++
 tb/tb_program_loader.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//   Sequential DMA-style loader that copies a block of 32-bit words from the
//   HD (disk) read port into instruction memory through the memory's write
//   port. The lfhd path uses it to pull the OS or a user program into
//   instruction memory before or while the BIOS runs.
//
//   One word moves per READ -> WAIT(HD_LAT) -> WRITE sequence, so each word
//   costs HD_LAT+2 cycles. A request costs 2 + numWords*(HD_LAT+2) cycles
//   from the cycle start is sampled to the done pulse.
//
// Parameters
//   HD_LAT      HD read latency in cycles (>= 1): hdRead cycle -> hdData valid
//   IMEM_DEPTH  instruction memory depth in words (legal addresses 0..DEPTH-1)
//   WRITE_CODE  controleSalvaInstrucao value that commits one word
//
// Ports
//   clock                       system clock, rising edge
//   reset                       synchronous, active-high
//   start                       single-cycle load request (only seen in IDLE)
//   hdBase / memBase / numWords request descriptor, latched on start
//   hdAddr, hdRead              HD read address and strobe
//   hdData                      HD read data, valid HD_LAT cycles after hdRead
//   entradaDeInstrucao          word being written to instruction memory
//   posicaoParaSalvarInstrucao  destination word address
//   controleSalvaInstrucao      WRITE_CODE for one cycle per word, else 0
//   busy                        high in CHECK/READ/WAIT/WRITE
//   done                        one-cycle pulse at the end of every request
//   error                       destination range violation of last request
//   wordsLoaded                 words committed by current/last request
module program_loader #(
  parameter int         HD_LAT     = 1,
  parameter int         IMEM_DEPTH = 201,
  parameter logic [2:0] WRITE_CODE = 3'b001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] hdBase,
  input  logic [31:0] memBase,
  input  logic [31:0] numWords,
  output logic [31:0] hdAddr,
  output logic        hdRead,
  input  logic [31:0] hdData,
  output logic [31:0] entradaDeInstrucao,
  output logic [31:0] posicaoParaSalvarInstrucao,
  output logic [2:0]  controleSalvaInstrucao,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] wordsLoaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // WAIT counts down from HD_LAT-1; the edge leaving the count of zero is
  // the one on which hdData is valid and gets captured.
  localparam logic [31:0] WAIT_LAST = 32'(HD_LAT - 1);

  state_t      state;
  logic [31:0] hd_base_q;
  logic [31:0] mem_base_q;
  logic [31:0] num_words_q;
  logic [31:0] idx;
  logic [31:0] wait_cnt;
  logic [31:0] idx_next;

  // The end address is formed in 33 bits so a memBase near 2^32 cannot wrap
  // around and look like an in-range request.
  function automatic logic range_bad(input logic [31:0] base,
                                     input logic [31:0] count);
    logic [32:0] end_excl;
    end_excl = {1'b0, base} + {1'b0, count};
    return (end_excl > 33'(IMEM_DEPTH));
  endfunction

  assign idx_next = idx + 32'd1;

  // Request descriptor: pure data, captured whenever a request is accepted.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && start) begin
      hd_base_q   <= hdBase;
      mem_base_q  <= memBase;
      num_words_q <= numWords;
    end
  end

  // Control FSM with registered outputs. Each output is assigned on the edge
  // that enters the state it belongs to, so it is valid for that whole state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                      <= S_IDLE;
      idx                        <= '0;
      wait_cnt                   <= '0;
      hdAddr                     <= '0;
      hdRead                     <= 1'b0;
      entradaDeInstrucao         <= '0;
      posicaoParaSalvarInstrucao <= '0;
      controleSalvaInstrucao     <= 3'b000;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      error                      <= 1'b0;
      wordsLoaded                <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed by a transition below.
      hdRead                 <= 1'b0;
      controleSalvaInstrucao <= 3'b000;
      done                   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            idx         <= '0;
            wordsLoaded <= '0;
            error       <= 1'b0;
            busy        <= 1'b1;
            state       <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (num_words_q == 32'd0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (range_bad(mem_base_q, num_words_q)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            hdRead <= 1'b1;
            hdAddr <= hd_base_q + idx;
            state  <= S_READ;
          end
        end

        S_READ: begin
          wait_cnt <= WAIT_LAST;
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == 32'd0) begin
            entradaDeInstrucao         <= hdData;
            posicaoParaSalvarInstrucao <= mem_base_q + idx;
            controleSalvaInstrucao     <= WRITE_CODE;
            state                      <= S_WRITE;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end

        S_WRITE: begin
          idx         <= idx_next;
          wordsLoaded <= wordsLoaded + 32'd1;
          if (idx_next == num_words_q) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            // HD address wraps modulo 2^32 by plain 32-bit addition.
            hdRead <= 1'b1;
            hdAddr <= hd_base_q + idx_next;
            state  <= S_READ;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader. Two instances share one clock: index 0 uses
// HD_LAT=1, index 1 uses HD_LAT=3. An HD model answers reads after the
// instance's latency (random garbage otherwise), a negedge monitor logs every
// read, write and done event with its cycle number, and each test compares
// the logs against timing and contents derived from the loader's rules.
module tb_program_loader;

  localparam int         DEPTH = 201;
  localparam logic [2:0] WCODE = 3'b001;
  localparam int         LOGN  = 512;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int lat_of[2] = '{1, 3};

  logic        reset_s[2];
  logic        start_s[2];
  logic [31:0] hdBase_s[2];
  logic [31:0] memBase_s[2];
  logic [31:0] numWords_s[2];
  logic [31:0] hdAddr_s[2];
  logic        hdRead_s[2];
  logic [31:0] hdData_s[2];
  logic [31:0] ent_s[2];
  logic [31:0] pos_s[2];
  logic [2:0]  ctl_s[2];
  logic        busy_s[2];
  logic        done_s[2];
  logic        error_s[2];
  logic [31:0] wl_s[2];

  program_loader #(.HD_LAT(1), .IMEM_DEPTH(DEPTH), .WRITE_CODE(WCODE)) dut_a (
    .clock(clock), .reset(reset_s[0]), .start(start_s[0]),
    .hdBase(hdBase_s[0]), .memBase(memBase_s[0]), .numWords(numWords_s[0]),
    .hdAddr(hdAddr_s[0]), .hdRead(hdRead_s[0]), .hdData(hdData_s[0]),
    .entradaDeInstrucao(ent_s[0]), .posicaoParaSalvarInstrucao(pos_s[0]),
    .controleSalvaInstrucao(ctl_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .error(error_s[0]), .wordsLoaded(wl_s[0]));

  program_loader #(.HD_LAT(3), .IMEM_DEPTH(DEPTH), .WRITE_CODE(WCODE)) dut_b (
    .clock(clock), .reset(reset_s[1]), .start(start_s[1]),
    .hdBase(hdBase_s[1]), .memBase(memBase_s[1]), .numWords(numWords_s[1]),
    .hdAddr(hdAddr_s[1]), .hdRead(hdRead_s[1]), .hdData(hdData_s[1]),
    .entradaDeInstrucao(ent_s[1]), .posicaoParaSalvarInstrucao(pos_s[1]),
    .controleSalvaInstrucao(ctl_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .error(error_s[1]), .wordsLoaded(wl_s[1]));

  // HD model: 256-word disk image indexed by the low address byte.
  logic [31:0] hd_mem[256];
  logic        hv[2][3];
  logic [31:0] ha[2][3];

  // At the edge ending cycle c the data for a read issued in cycle
  // c+1-HD_LAT is launched so it is valid throughout cycle c+1.
  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      logic        v;
      logic [31:0] a;
      if (d == 0) begin
        v = hdRead_s[0];
        a = hdAddr_s[0];
      end else begin
        v = hv[1][1];
        a = ha[1][1];
      end
      hdData_s[d] <= (v === 1'b1) ? hd_mem[a[7:0]] : $urandom;
      hv[d][0] <= hdRead_s[d];
      ha[d][0] <= hdAddr_s[d];
      hv[d][1] <= hv[d][0];
      ha[d][1] <= ha[d][0];
      hv[d][2] <= hv[d][1];
      ha[d][2] <= ha[d][1];
    end
  end

  // Event logs.
  int          wr_n[2]   = '{0, 0};
  int          rd_n[2]   = '{0, 0};
  int          dn_n[2]   = '{0, 0};
  int          busy_n[2] = '{0, 0};
  int          wr_cyc[2][LOGN];
  logic [31:0] wr_addr[2][LOGN];
  logic [31:0] wr_data[2][LOGN];
  logic [2:0]  wr_code[2][LOGN];
  int          rd_cyc[2][LOGN];
  logic [31:0] rd_addr[2][LOGN];
  int          dn_cyc[2][LOGN];

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (ctl_s[d] != 3'b000 && wr_n[d] < LOGN) begin
        wr_cyc[d][wr_n[d]]  = cyc;
        wr_addr[d][wr_n[d]] = pos_s[d];
        wr_data[d][wr_n[d]] = ent_s[d];
        wr_code[d][wr_n[d]] = ctl_s[d];
        wr_n[d]             = wr_n[d] + 1;
      end
      if (hdRead_s[d] && rd_n[d] < LOGN) begin
        rd_cyc[d][rd_n[d]]  = cyc;
        rd_addr[d][rd_n[d]] = hdAddr_s[d];
        rd_n[d]             = rd_n[d] + 1;
      end
      if (done_s[d] && dn_n[d] < LOGN) begin
        dn_cyc[d][dn_n[d]] = cyc;
        dn_n[d]            = dn_n[d] + 1;
      end
      if (busy_s[d]) busy_n[d] = busy_n[d] + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  // Reference rules.
  function automatic bit exp_err(input logic [31:0] mb, input logic [31:0] nw);
    logic [32:0] e;
    e = {1'b0, mb} + {1'b0, nw};
    return (nw != 0) && (e > 33'(DEPTH));
  endfunction

  function automatic int exp_words(input logic [31:0] mb, input logic [31:0] nw);
    return exp_err(mb, nw) ? 0 : int'(nw);
  endfunction

  function automatic int exp_delta(input int lat, input logic [31:0] mb,
                                   input logic [31:0] nw);
    return 2 + exp_words(mb, nw) * (lat + 2);
  endfunction

  // Per-run snapshot and results.
  int s_wr, s_rd, s_dn, s_busy, st_cyc;
  int got_wr, got_rd, got_dn, got_busy, got_delta;

  // Issues one request on instance d; optionally pulses start again 'extra'
  // cycles later with scrambled descriptor inputs. Returns 3 cycles after
  // done (or after a 300-cycle bound).
  task automatic run_load(input int d, input logic [31:0] hb,
                          input logic [31:0] mb, input logic [31:0] nw,
                          input int extra);
    @(negedge clock); #1;
    s_wr = wr_n[d]; s_rd = rd_n[d]; s_dn = dn_n[d]; s_busy = busy_n[d];
    hdBase_s[d] = hb; memBase_s[d] = mb; numWords_s[d] = nw;
    start_s[d] = 1'b1;
    st_cyc = cyc;
    for (int k = 1; k < 300; k++) begin
      @(negedge clock); #1;
      start_s[d]    = (k == extra);
      hdBase_s[d]   = $urandom;
      memBase_s[d]  = $urandom;
      numWords_s[d] = $urandom;
      if (dn_n[d] != s_dn) break;
    end
    start_s[d] = 1'b0;
    repeat (3) begin @(negedge clock); #1; end
    got_wr    = wr_n[d] - s_wr;
    got_rd    = rd_n[d] - s_rd;
    got_dn    = dn_n[d] - s_dn;
    got_busy  = busy_n[d] - s_busy;
    got_delta = dn_cyc[d][s_dn] - st_cyc;
  endtask

  task automatic test_reset();
    repeat (3) begin @(negedge clock); #1; end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({hdAddr_s[d], hdRead_s[d], ent_s[d], pos_s[d], ctl_s[d], busy_s[d],
           done_s[d], error_s[d], wl_s[d]} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d got addr=%h rd=%b ent=%h pos=%h ctl=%b busy=%b done=%b err=%b wl=%h want all 0",
                 d, hdAddr_s[d], hdRead_s[d], ent_s[d], pos_s[d], ctl_s[d],
                 busy_s[d], done_s[d], error_s[d], wl_s[d]);
      end
    end
    reset_s[0] = 1'b0;
    reset_s[1] = 1'b0;
    repeat (2) begin @(negedge clock); #1; end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if ({hdRead_s[d], ctl_s[d], busy_s[d], done_s[d]} !== '0) begin
        n_bad++;
        $display("FAIL idle_after_reset dut%0d got rd=%b ctl=%b busy=%b done=%b want 0",
                 d, hdRead_s[d], ctl_s[d], busy_s[d], done_s[d]);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp_d[3];
    exp_d = '{32'h6800_0004, 32'h6800_0001, 32'h6400_0000};
    run_load(0, 32'd10, 32'd0, 32'd3, 0);
    n_vec++; if (got_wr !== 3) begin n_bad++; $display("FAIL basic_write_count got %0d want 3", got_wr); end
    if (got_wr == 3) begin
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (wr_addr[0][s_wr+k] !== 32'(k) || wr_data[0][s_wr+k] !== exp_d[k]) begin
          n_bad++;
          $display("FAIL basic_write%0d got (%0d,%h) want (%0d,%h)", k,
                   wr_addr[0][s_wr+k], wr_data[0][s_wr+k], k, exp_d[k]);
        end
      end
    end
    n_vec++; if (got_dn !== 1) begin n_bad++; $display("FAIL basic_done_count got %0d want 1", got_dn); end
    n_vec++; if (got_delta !== 11) begin n_bad++; $display("FAIL basic_done_latency got %0d want 11", got_delta); end
    n_vec++; if (wl_s[0] !== 32'd3) begin n_bad++; $display("FAIL basic_wordsLoaded got %0d want 3", wl_s[0]); end
    n_vec++; if (error_s[0] !== 1'b0) begin n_bad++; $display("FAIL basic_error got %b want 0", error_s[0]); end
    n_vec++; if (got_busy !== 10) begin n_bad++; $display("FAIL basic_busy_cycles got %0d want 10", got_busy); end
  endtask

  task automatic test_zero();
    run_load(0, 32'd5, 32'd7, 32'd0, 0);
    n_vec++; if (got_rd !== 0 || got_wr !== 0) begin n_bad++; $display("FAIL zero_activity got rd=%0d wr=%0d want 0/0", got_rd, got_wr); end
    n_vec++; if (got_dn !== 1 || got_delta !== 2) begin n_bad++; $display("FAIL zero_done got cnt=%0d lat=%0d want 1/2", got_dn, got_delta); end
    n_vec++; if (got_busy !== 1) begin n_bad++; $display("FAIL zero_busy_cycles got %0d want 1", got_busy); end
    n_vec++; if (error_s[0] !== 1'b0) begin n_bad++; $display("FAIL zero_error got %b want 0", error_s[0]); end
  endtask

  task automatic test_range();
    run_load(0, 32'd20, 32'd199, 32'd3, 0);
    n_vec++; if (error_s[0] !== 1'b1) begin n_bad++; $display("FAIL range_error got %b want 1", error_s[0]); end
    n_vec++; if (got_wr !== 0 || got_rd !== 0) begin n_bad++; $display("FAIL range_activity got rd=%0d wr=%0d want 0/0", got_rd, got_wr); end
    n_vec++; if (got_dn !== 1 || got_delta !== 2) begin n_bad++; $display("FAIL range_done got cnt=%0d lat=%0d want 1/2", got_dn, got_delta); end
    run_load(0, 32'd20, 32'd198, 32'd3, 0);
    n_vec++; if (error_s[0] !== 1'b0) begin n_bad++; $display("FAIL edge_error got %b want 0", error_s[0]); end
    n_vec++; if (got_wr !== 3) begin n_bad++; $display("FAIL edge_write_count got %0d want 3", got_wr); end
    if (got_wr == 3) begin
      for (int k = 0; k < 3; k++) begin
        logic [31:0] a;
        a = 32'd20 + 32'(k);
        n_vec++;
        if (wr_addr[0][s_wr+k] !== 32'(198 + k) || wr_data[0][s_wr+k] !== hd_mem[a[7:0]]) begin
          n_bad++;
          $display("FAIL edge_write%0d got (%0d,%h) want (%0d,%h)", k,
                   wr_addr[0][s_wr+k], wr_data[0][s_wr+k], 198 + k, hd_mem[a[7:0]]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int b_wr, b_rd, b_dn;
    @(negedge clock); #1;
    b_wr = wr_n[0]; b_rd = rd_n[0]; b_dn = dn_n[0];
    hdBase_s[0] = 32'd60; memBase_s[0] = 32'd10; numWords_s[0] = 32'd5;
    start_s[0] = 1'b1;
    @(negedge clock); #1;
    start_s[0] = 1'b0;
    // Cycle start+6 is the WAIT of word 2 with HD_LAT=1.
    repeat (5) begin @(negedge clock); #1; end
    reset_s[0] = 1'b1;
    @(negedge clock); #1;
    n_vec++;
    if ({hdAddr_s[0], hdRead_s[0], ent_s[0], pos_s[0], ctl_s[0], busy_s[0],
         done_s[0], error_s[0], wl_s[0]} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs got addr=%h rd=%b ent=%h pos=%h ctl=%b busy=%b done=%b err=%b wl=%h want all 0",
               hdAddr_s[0], hdRead_s[0], ent_s[0], pos_s[0], ctl_s[0],
               busy_s[0], done_s[0], error_s[0], wl_s[0]);
    end
    reset_s[0] = 1'b0;
    repeat (10) begin @(negedge clock); #1; end
    n_vec++;
    if (wr_n[0] - b_wr !== 1 || rd_n[0] - b_rd !== 2 || dn_n[0] - b_dn !== 0) begin
      n_bad++;
      $display("FAIL midreset_activity got wr=%0d rd=%0d done=%0d want 1/2/0",
               wr_n[0] - b_wr, rd_n[0] - b_rd, dn_n[0] - b_dn);
    end
    run_load(0, 32'd30, 32'd40, 32'd2, 0);
    n_vec++;
    if (got_wr !== 2 || got_dn !== 1 || got_delta !== 8 || wl_s[0] !== 32'd2) begin
      n_bad++;
      $display("FAIL midreset_restart got wr=%0d done=%0d lat=%0d wl=%0d want 2/1/8/2",
               got_wr, got_dn, got_delta, wl_s[0]);
    end
  endtask

  task automatic test_busy_start();
    run_load(0, 32'd50, 32'd100, 32'd4, 3);
    n_vec++;
    if (got_dn !== 1 || got_wr !== 4 || got_delta !== 14) begin
      n_bad++;
      $display("FAIL busy_start got done=%0d wr=%0d lat=%0d want 1/4/14", got_dn, got_wr, got_delta);
    end
    if (got_wr == 4) begin
      for (int k = 0; k < 4; k++) begin
        logic [31:0] a;
        a = 32'd50 + 32'(k);
        n_vec++;
        if (wr_addr[0][s_wr+k] !== 32'(100 + k) || wr_data[0][s_wr+k] !== hd_mem[a[7:0]]) begin
          n_bad++;
          $display("FAIL busy_start_write%0d got (%0d,%h) want (%0d,%h)", k,
                   wr_addr[0][s_wr+k], wr_data[0][s_wr+k], 100 + k, hd_mem[a[7:0]]);
        end
      end
    end
  endtask

  task automatic test_lat3();
    run_load(1, 32'd10, 32'd0, 32'd2, 0);
    n_vec++;
    if (got_wr !== 2 || got_rd !== 2 || got_dn !== 1 || got_delta !== 12) begin
      n_bad++;
      $display("FAIL lat3_summary got wr=%0d rd=%0d done=%0d lat=%0d want 2/2/1/12",
               got_wr, got_rd, got_dn, got_delta);
    end
    if (got_wr == 2 && got_rd == 2) begin
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (wr_cyc[1][s_wr+k] - rd_cyc[1][s_rd+k] !== 4 || wr_data[1][s_wr+k] !== hd_mem[10+k]) begin
          n_bad++;
          $display("FAIL lat3_word%0d got gap=%0d data=%h want gap=4 data=%h", k,
                   wr_cyc[1][s_wr+k] - rd_cyc[1][s_rd+k], wr_data[1][s_wr+k], hd_mem[10+k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int          d, lat, n, ex, rd0;
      logic [31:0] hb, mb, nw, a;
      d   = it % 2;
      lat = lat_of[d];
      hb  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      nw  = $urandom_range(0, 5);
      mb  = ($urandom_range(0, 2) == 0) ? 32'(DEPTH) - nw + 32'($urandom_range(0, 1))
                                        : 32'($urandom_range(0, 205));
      ex  = $urandom_range(0, 1);
      run_load(d, hb, mb, nw, ex);
      n = exp_words(mb, nw);
      n_vec++;
      if (got_dn !== 1 || got_delta !== exp_delta(lat, mb, nw)) begin
        n_bad++;
        $display("FAIL rnd%0d_done got cnt=%0d lat=%0d want 1/%0d", it, got_dn, got_delta, exp_delta(lat, mb, nw));
      end
      n_vec++;
      if (error_s[d] !== exp_err(mb, nw) || wl_s[d] !== 32'(n) || got_busy !== exp_delta(lat, mb, nw) - 1) begin
        n_bad++;
        $display("FAIL rnd%0d_status got err=%b wl=%0d busy=%0d want %b/%0d/%0d", it,
                 error_s[d], wl_s[d], got_busy, exp_err(mb, nw), n, exp_delta(lat, mb, nw) - 1);
      end
      n_vec++;
      if (got_wr !== n || got_rd !== n) begin
        n_bad++;
        $display("FAIL rnd%0d_counts got wr=%0d rd=%0d want %0d", it, got_wr, got_rd, n);
      end
      if (got_wr == n && got_rd == n) begin
        for (int k = 0; k < n; k++) begin
          a   = hb + 32'(k);
          rd0 = st_cyc + 2 + k * (lat + 2);
          n_vec++;
          if (rd_addr[d][s_rd+k] !== a || rd_cyc[d][s_rd+k] !== rd0) begin
            n_bad++;
            $display("FAIL rnd%0d_read%0d got (%h @%0d) want (%h @%0d)", it, k,
                     rd_addr[d][s_rd+k], rd_cyc[d][s_rd+k], a, rd0);
          end
          n_vec++;
          if (wr_addr[d][s_wr+k] !== mb + 32'(k) || wr_data[d][s_wr+k] !== hd_mem[a[7:0]] ||
              wr_cyc[d][s_wr+k] !== rd0 + lat + 1 || wr_code[d][s_wr+k] !== WCODE) begin
            n_bad++;
            $display("FAIL rnd%0d_write%0d got (%0d,%h,@%0d,%b) want (%0d,%h,@%0d,%b)", it, k,
                     wr_addr[d][s_wr+k], wr_data[d][s_wr+k], wr_cyc[d][s_wr+k], wr_code[d][s_wr+k],
                     mb + 32'(k), hd_mem[a[7:0]], rd0 + lat + 1, WCODE);
          end
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d]    = 1'b1;
      start_s[d]    = 1'b0;
      hdBase_s[d]   = '0;
      memBase_s[d]  = '0;
      numWords_s[d] = '0;
    end
    for (int i = 0; i < 256; i++) hd_mem[i] = $urandom;
    hd_mem[10] = 32'h6800_0004;
    hd_mem[11] = 32'h6800_0001;
    hd_mem[12] = 32'h6400_0000;

    test_reset();
    test_basic();
    test_zero();
    test_range();
    test_reset_mid();
    test_busy_start();
    test_lat3();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
